// File: rtl/area_stat_box_if.sv
// rtl/area_stat_box_if.sv - pixel stream, forwarded stream and frame statistics bundle
interface area_stat_box_if #(
  parameter int X_BITS    = 11,
  parameter int Y_BITS    = 11,
  parameter int AREA_BITS = 22
);
  logic                 en;
  logic                 i_binary;
  logic                 i_hs;
  logic                 i_vs;
  logic                 i_de;
  logic                 post_frame_vsync;
  logic                 post_frame_href;
  logic                 post_frame_clken;
  logic                 post_img_Bit;
  logic [AREA_BITS-1:0] area_cnt;
  logic [X_BITS-1:0]    x_min;
  logic [X_BITS-1:0]    x_max;
  logic [Y_BITS-1:0]    y_min;
  logic [Y_BITS-1:0]    y_max;
  logic                 obj_found;
  logic                 result_valid;

  modport master (
    output en, i_binary, i_hs, i_vs, i_de,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
    input  area_cnt, x_min, x_max, y_min, y_max, obj_found, result_valid
  );

  modport slave (
    input  en, i_binary, i_hs, i_vs, i_de,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
    output area_cnt, x_min, x_max, y_min, y_max, obj_found, result_valid
  );
endinterface

// File: rtl/area_stat_box.sv
// rtl/area_stat_box.sv - per-frame foreground area and bounding box of a binary pixel stream
module area_stat_box #(
  parameter int X_BITS      = 11,
  parameter int Y_BITS      = 11,
  parameter int AREA_BITS   = 22,
  parameter int VS_ACT_HIGH = 1,
  parameter int DRAW_BOX    = 1
) (
  input logic             pixelclk,
  input logic             rst_n,
  area_stat_box_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACTIVE, LATCH} state_t;

  state_t               state;
  logic                 vs_act, vs_act_d, de_d;
  logic                 frame_start, frame_end, de_fall;
  logic                 acc_en, ov_hit, en_lat;
  logic [X_BITS-1:0]    x_cnt, acc_x_min, acc_x_max;
  logic [Y_BITS-1:0]    y_cnt, acc_y_min, acc_y_max;
  logic [AREA_BITS-1:0] acc_area;

  assign vs_act      = (VS_ACT_HIGH != 0) ? bus.i_vs : ~bus.i_vs;
  assign frame_start = vs_act & ~vs_act_d;
  assign frame_end   = ~vs_act & vs_act_d;
  assign de_fall     = de_d & ~bus.i_de;
  assign acc_en      = (state == ACTIVE) & vs_act & en_lat & bus.i_de & bus.i_binary;

  // Overlay is evaluated on the input side against the latched box, so it lands
  // on the same delayed pixel as the x,y it was computed from.
  always_comb begin
    ov_hit = 1'b0;
    if ((DRAW_BOX != 0) && bus.obj_found) begin
      ov_hit = (((x_cnt == bus.x_min) || (x_cnt == bus.x_max)) &&
                (y_cnt >= bus.y_min) && (y_cnt <= bus.y_max)) ||
               (((y_cnt == bus.y_min) || (y_cnt == bus.y_max)) &&
                (x_cnt >= bus.x_min) && (x_cnt <= bus.x_max));
    end
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_act_d             <= 1'b0;
      de_d                 <= 1'b0;
      bus.post_frame_vsync <= 1'b0;
      bus.post_frame_href  <= 1'b0;
      bus.post_frame_clken <= 1'b0;
      bus.post_img_Bit     <= 1'b0;
    end else begin
      vs_act_d             <= vs_act;
      de_d                 <= bus.i_de;
      bus.post_frame_vsync <= bus.i_vs;
      bus.post_frame_href  <= bus.i_hs;
      bus.post_frame_clken <= bus.i_de;
      bus.post_img_Bit     <= bus.i_de & (bus.i_binary | ov_hit);
    end
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (frame_start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (bus.i_de) begin
        x_cnt <= x_cnt + 1'b1;
      end else if (de_fall) begin
        x_cnt <= '0;
      end
      if (de_fall) begin
        y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      en_lat           <= 1'b0;
      acc_area         <= '0;
      acc_x_min        <= '1;
      acc_x_max        <= '0;
      acc_y_min        <= '1;
      acc_y_max        <= '0;
      bus.area_cnt     <= '0;
      bus.x_min        <= '0;
      bus.x_max        <= '0;
      bus.y_min        <= '0;
      bus.y_max        <= '0;
      bus.obj_found    <= 1'b0;
      bus.result_valid <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            acc_area  <= '0;
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
            en_lat    <= bus.en;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (acc_en) begin
            if (acc_area != '1) acc_area <= acc_area + 1'b1;
            if (x_cnt < acc_x_min) acc_x_min <= x_cnt;
            if (x_cnt > acc_x_max) acc_x_max <= x_cnt;
            if (y_cnt < acc_y_min) acc_y_min <= y_cnt;
            if (y_cnt > acc_y_max) acc_y_max <= y_cnt;
          end
          if (frame_end) state <= LATCH;
        end
        LATCH: begin
          if (en_lat) begin
            bus.area_cnt     <= acc_area;
            bus.obj_found    <= (acc_area != '0);
            bus.x_min        <= (acc_area != '0) ? acc_x_min : '0;
            bus.x_max        <= (acc_area != '0) ? acc_x_max : '0;
            bus.y_min        <= (acc_area != '0) ? acc_y_min : '0;
            bus.y_max        <= (acc_area != '0) ? acc_y_max : '0;
            bus.result_valid <= 1'b1;
          end
          // A back-to-back frame start restarts accumulation while the latch above completes.
          if (frame_start) begin
            acc_area  <= '0;
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
            en_lat    <= bus.en;
            state     <= ACTIVE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
